// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the boot loader slice.
// BOOT_LOADER_CHECKSUM_EN adds the ERROR state used by the load checksum.
package boot_loader_pkg;

  localparam int unsigned D_ADDR_W_DEF = 10;
  localparam int unsigned CNT_W_DEF    = 9;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_LOAD_I,
    ST_RUN
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    ST_ERROR
`endif
  } bl_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Valid/ready word stream feeding the boot loader.
interface boot_loader_if #(
  parameter int unsigned DATA_W = boot_loader_pkg::WORD_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/boot_loader_load_counter.sv
// Region beat counter and byte-address generator, shared by the data and
// instruction regions; the address wraps naturally at 2^D_ADDR_W.
module boot_loader_load_counter #(
  parameter int unsigned D_ADDR_W = 10,
  parameter int unsigned CNT_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [CNT_W-1:0]    target_i,
  output logic                last_o,
  output logic [D_ADDR_W-1:0] addr_o
);

  logic [CNT_W-1:0]    count_q;
  logic [D_ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
      addr_q  <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
      addr_q  <= addr_q + D_ADDR_W'(4);
    end
  end

  assign last_o = (count_q == (target_i - CNT_W'(1)));
  assign addr_o = addr_q;

endmodule

// File: rtl/boot_loader.sv
// Streams words into data then instruction BRAM, then releases the core.
// Optional load checksum: define BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned D_ADDR_W = D_ADDR_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt,
  input  logic [CNT_W-1:0]    data_count,
  input  logic [CNT_W-1:0]    instr_count,
  boot_loader_if.slave        in_bus,
  output logic [D_ADDR_W-1:0] d_w_addr,
  output logic [WORD_W-1:0]   d_w_dat,
  output logic                d_w_enb,
  output logic [D_ADDR_W-1:0] i_w_addr,
  output logic [WORD_W-1:0]   i_w_dat,
  output logic                i_w_enb,
  output logic                d_init_done,
  output logic                pc_stall,
  output logic                i_r_enb,
  output logic                rd_enbl,
  output logic                busy,
`ifdef BOOT_LOADER_CHECKSUM_EN
  input  logic [WORD_W-1:0]   expected_sum,
  output logic                sum_err,
`endif
  output logic                done
);

  bl_state_e state_q, state_d, end_st;

  logic [CNT_W-1:0]    data_cnt_q, instr_cnt_q, target;
  logic                in_ready_q, busy_q, done_q, pc_stall_q, run_q;
  logic                d_init_done_q;
  logic                d_w_enb_q, i_w_enb_q;
  logic [D_ADDR_W-1:0] d_w_addr_q, i_w_addr_q, cnt_addr;
  logic [WORD_W-1:0]   d_w_dat_q, i_w_dat_q;
  logic                beat, start_ok, cnt_clr, cnt_last;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              sum_err_q;
`endif

  boot_loader_load_counter #(
    .D_ADDR_W (D_ADDR_W),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .inc_i    (beat),
    .target_i (target),
    .last_o   (cnt_last),
    .addr_o   (cnt_addr)
  );

  always_comb begin
    beat     = in_bus.in_valid && in_ready_q;
    start_ok = start && (state_q == ST_IDLE);
    target   = (state_q == ST_LOAD_D) ? data_cnt_q : instr_cnt_q;
    cnt_clr  = start_ok;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d    = sum_q + in_bus.in_data;
    end_st   = (sum_d == expected_sum) ? ST_RUN : ST_ERROR;
`else
    end_st   = ST_RUN;
`endif
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (data_count != '0)       state_d = ST_LOAD_D;
          else if (instr_count != '0) state_d = ST_LOAD_I;
          else                        state_d = ST_RUN;
        end
      end
      ST_LOAD_D: begin
        if (beat && cnt_last) begin
          cnt_clr = 1'b1;
          state_d = (instr_cnt_q != '0) ? ST_LOAD_I : end_st;
        end
      end
      ST_LOAD_I: if (beat && cnt_last) state_d = end_st;
      ST_RUN:    if (halt) state_d = ST_IDLE;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      data_cnt_q    <= '0;
      instr_cnt_q   <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_stall_q    <= 1'b1;
      run_q         <= 1'b0;
      d_init_done_q <= 1'b0;
      d_w_enb_q     <= 1'b0;
      d_w_addr_q    <= '0;
      d_w_dat_q     <= '0;
      i_w_enb_q     <= 1'b0;
      i_w_addr_q    <= '0;
      i_w_dat_q     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q         <= '0;
      sum_err_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_LOAD_D) || (state_d == ST_LOAD_I);
      busy_q     <= (state_d == ST_LOAD_D) || (state_d == ST_LOAD_I);
      pc_stall_q <= (state_d != ST_RUN);
      run_q      <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_RUN) && (state_q != ST_RUN);
      if (start_ok) begin
        data_cnt_q  <= data_count;
        instr_cnt_q <= instr_count;
      end
      d_w_enb_q <= beat && (state_q == ST_LOAD_D);
      if (beat && (state_q == ST_LOAD_D)) begin
        d_w_addr_q <= cnt_addr;
        d_w_dat_q  <= in_bus.in_data;
      end
      i_w_enb_q <= beat && (state_q == ST_LOAD_I);
      if (beat && (state_q == ST_LOAD_I)) begin
        i_w_addr_q <= cnt_addr;
        i_w_dat_q  <= in_bus.in_data;
      end
      // Set one cycle after leaving LOAD_D, so it never overlaps the last data write.
      if (state_d == ST_IDLE)
        d_init_done_q <= 1'b0;
      else if ((state_q != ST_IDLE) && (state_q != ST_LOAD_D))
        d_init_done_q <= 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      if (start_ok)  sum_q <= '0;
      else if (beat) sum_q <= sum_d;
      sum_err_q <= (state_d == ST_ERROR);
`endif
    end
  end

  assign in_bus.in_ready = in_ready_q;
  assign d_w_addr        = d_w_addr_q;
  assign d_w_dat         = d_w_dat_q;
  assign d_w_enb         = d_w_enb_q;
  assign i_w_addr        = i_w_addr_q;
  assign i_w_dat         = i_w_dat_q;
  assign i_w_enb         = i_w_enb_q;
  assign d_init_done     = d_init_done_q;
  assign pc_stall        = pc_stall_q;
  assign i_r_enb         = run_q;
  assign rd_enbl         = run_q;
  assign busy            = busy_q;
  assign done            = done_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign sum_err         = sum_err_q;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a phase-level reference model.
module tb_boot_loader;

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 9;
  localparam int P_IDLE = 0, P_DATA = 1, P_INSTR = 2, P_RUN = 3, P_ERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, halt;
  logic [CW-1:0] data_count, instr_count;
  logic [AW-1:0] d_w_addr, i_w_addr;
  logic [31:0]   d_w_dat, i_w_dat;
  logic          d_w_enb, i_w_enb, d_init_done, pc_stall, i_r_enb, rd_enbl, busy, done;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]   expected_sum = '0;
  logic          sum_err;
  logic [31:0]   sum_skew = '0;
`endif

  boot_loader_if bus ();

  boot_loader #(.D_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .data_count(data_count), .instr_count(instr_count), .in_bus(bus),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_init_done(d_init_done), .pc_stall(pc_stall), .i_r_enb(i_r_enb),
    .rd_enbl(rd_enbl), .busy(busy),
`ifdef BOOT_LOADER_CHECKSUM_EN
    .expected_sum(expected_sum), .sum_err(sum_err),
`endif
    .done(done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: load phase, beat index within region, expected outputs.
  int          m_ph = P_IDLE, m_k, m_nd, m_ni;
  bit          m_pend;
  logic [31:0] m_sum;
  logic        e_d_enb, e_i_enb, e_done, e_dinit;
  logic [AW-1:0] e_d_addr, e_i_addr;
  logic [31:0] e_d_dat, e_i_dat;

  task automatic m_end_load();
    bit bad;
    bad = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    bad = (m_sum != expected_sum);
`endif
    if (bad) m_ph = P_ERR;
    else begin m_ph = P_RUN; e_done = 1'b1; end
  endtask

  task automatic m_end_data();
    m_pend = 1'b1;
    m_k    = 0;
    if (m_ni != 0) m_ph = P_INSTR;
    else m_end_load();
  endtask

  always @(posedge clk) begin
    e_d_enb = 1'b0; e_i_enb = 1'b0; e_done = 1'b0;
    if (rst) begin
      m_ph = P_IDLE; m_k = 0; m_pend = 1'b0; m_sum = '0; e_dinit = 1'b0;
      e_d_addr = '0; e_d_dat = '0; e_i_addr = '0; e_i_dat = '0;
    end else begin
      if (m_pend) begin e_dinit = 1'b1; m_pend = 1'b0; end
      case (m_ph)
        P_IDLE: if (start) begin
          m_nd = int'(data_count); m_ni = int'(instr_count); m_k = 0; m_sum = '0;
          if (m_nd != 0) m_ph = P_DATA;
          else if (m_ni != 0) m_end_data();
          else begin m_pend = 1'b1; m_ph = P_RUN; e_done = 1'b1; end
        end
        P_DATA, P_INSTR: if (bus.in_valid) begin
          m_sum = m_sum + bus.in_data;
          if (m_ph == P_DATA) begin
            e_d_enb = 1'b1; e_d_addr = AW'((m_k * 4) % (1 << AW)); e_d_dat = bus.in_data;
          end else begin
            e_i_enb = 1'b1; e_i_addr = AW'((m_k * 4) % (1 << AW)); e_i_dat = bus.in_data;
          end
          m_k++;
          if (m_ph == P_DATA && m_k == m_nd) m_end_data();
          else if (m_ph == P_INSTR && m_k == m_ni) m_end_load();
        end
        P_RUN: if (halt) begin m_ph = P_IDLE; e_dinit = 1'b0; end
        default: ;
      endcase
    end
  end

  bit            cmp_en = 1'b0;
  logic [AW-1:0] dq_a[$], iq_a[$];
  logic [31:0]   dq_d[$], iq_d[$];
  int            n_done;

  always @(negedge clk) if (cmp_en) begin
    chk("in_ready", 32'(bus.in_ready), 32'(m_ph == P_DATA || m_ph == P_INSTR));
    chk("busy", 32'(busy), 32'(m_ph == P_DATA || m_ph == P_INSTR));
    chk("pc_stall", 32'(pc_stall), 32'(m_ph != P_RUN));
    chk("i_r_enb", 32'(i_r_enb), 32'(m_ph == P_RUN));
    chk("rd_enbl", 32'(rd_enbl), 32'(m_ph == P_RUN));
    chk("done", 32'(done), 32'(e_done));
    chk("d_init_done", 32'(d_init_done), 32'(e_dinit));
    chk("d_w_enb", 32'(d_w_enb), 32'(e_d_enb));
    chk("d_w_addr", 32'(d_w_addr), 32'(e_d_addr));
    chk("d_w_dat", d_w_dat, e_d_dat);
    chk("i_w_enb", 32'(i_w_enb), 32'(e_i_enb));
    chk("i_w_addr", 32'(i_w_addr), 32'(e_i_addr));
    chk("i_w_dat", i_w_dat, e_i_dat);
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("sum_err", 32'(sum_err), 32'(m_ph == P_ERR));
`endif
    if (d_w_enb) begin dq_a.push_back(d_w_addr); dq_d.push_back(d_w_dat); end
    if (i_w_enb) begin iq_a.push_back(i_w_addr); iq_d.push_back(i_w_dat); end
    if (done) n_done++;
  end

  logic [31:0] words[32];

  task automatic send_words(input int n, input bit gap, input bit poke);
    int i, cyc;
    i = 0; cyc = 0;
    while (i < n) begin
      if (cyc >= 200) begin chk("stream_timeout", 32'(i), 32'(n)); break; end
      @(negedge clk); cyc++; start = 1'b0; halt = 1'b0;
      if (poke && cyc == 3) begin start = 1'b1; halt = 1'b1; data_count = 7; instr_count = 7; end
      if (gap && (cyc % 2 == 0)) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1; bus.in_data = words[i];
        if (bus.in_ready) i++;
      end
    end
  endtask

  task automatic load(input int nd, input int ni, input bit gap, input bit poke, input int nsend);
    dq_a.delete(); dq_d.delete(); iq_a.delete(); iq_d.delete(); n_done = 0;
    @(negedge clk);
`ifdef BOOT_LOADER_CHECKSUM_EN
    expected_sum = sum_skew;
    for (int k = 0; k < nd + ni; k++) expected_sum = expected_sum + words[k];
`endif
    start = 1'b1; data_count = CW'(nd); instr_count = CW'(ni);
    send_words(nsend, gap, poke);
    @(negedge clk); start = 1'b0; halt = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic do_halt();
    @(negedge clk); halt = 1'b1;
    @(negedge clk); halt = 1'b0;
  endtask

  task automatic check_std_load(input string tag);
    chk({tag, "_d_count"}, 32'(dq_a.size()), 32'd2);
    chk({tag, "_d0_addr"}, 32'(dq_a[0]), 32'h0);
    chk({tag, "_d0_dat"}, dq_d[0], 32'h5);
    chk({tag, "_d1_addr"}, 32'(dq_a[1]), 32'h4);
    chk({tag, "_d1_dat"}, dq_d[1], 32'h3);
    chk({tag, "_i_count"}, 32'(iq_a.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk({tag, "_i_addr"}, 32'(iq_a[k]), 32'(4 * k));
      chk({tag, "_i_dat"}, iq_d[k], 32'h11 + 32'(k));
    end
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({tag, "_pc_stall"}, 32'(pc_stall), 32'd0);
    chk({tag, "_d_init_done"}, 32'(d_init_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; data_count = '0; instr_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    @(posedge clk); #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_pc_stall", 32'(pc_stall), 32'd1);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_d_init_done", 32'(d_init_done), 32'd0);
    rst = 1'b0;

    words[0] = 32'h5; words[1] = 32'h3;
    for (int k = 0; k < 6; k++) words[2 + k] = 32'h11 + 32'(k);
    load(2, 6, 1'b0, 1'b0, 8);
    repeat (2) @(negedge clk);
    check_std_load("full");

    @(negedge clk); halt = 1'b1; start = 1'b1; data_count = 2; instr_count = 6;
    @(negedge clk); halt = 1'b0; start = 1'b0;
    chk("halt_start_pc_stall", 32'(pc_stall), 32'd1);
    chk("halt_start_in_ready", 32'(bus.in_ready), 32'd0);
    chk("halt_start_i_r_enb", 32'(i_r_enb), 32'd0);
    chk("halt_start_d_init_done", 32'(d_init_done), 32'd0);
    @(negedge clk);
    chk("halt_start_ignored", 32'(bus.in_ready), 32'd0);

    load(2, 6, 1'b1, 1'b0, 8);
    repeat (2) @(negedge clk);
    check_std_load("gapped");

    do_halt();
    for (int k = 0; k < 3; k++) words[k] = 32'h21 + 32'(k);
    load(0, 3, 1'b0, 1'b0, 3);
    repeat (2) @(negedge clk);
    chk("nodata_d_count", 32'(dq_a.size()), 32'd0);
    chk("nodata_i_count", 32'(iq_a.size()), 32'd3);
    chk("nodata_i2_addr", 32'(iq_a[2]), 32'h8);
    chk("nodata_d_init_done", 32'(d_init_done), 32'd1);
    chk("nodata_run", 32'(pc_stall), 32'd0);

    do_halt();
    for (int k = 0; k < 6; k++) words[k] = 32'h31 + 32'(k);
    load(1, 5, 1'b0, 1'b1, 4);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hdead;
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_pc_stall", 32'(pc_stall), 32'd1);
    chk("abort_i_w_enb", 32'(i_w_enb), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort_i_count", 32'(iq_a.size()), 32'd3);
    chk("abort_d_count", 32'(dq_a.size()), 32'd1);

    for (int k = 0; k < 32; k++) words[k] = 32'h100 + 32'(k);
    load(0, 18, 1'b0, 1'b0, 18);
    repeat (2) @(negedge clk);
    chk("wrap_i_count", 32'(iq_a.size()), 32'd18);
    chk("wrap_i15_addr", 32'(iq_a[15]), 32'h3c);
    chk("wrap_i16_addr", 32'(iq_a[16]), 32'h0);
    chk("wrap_i17_addr", 32'(iq_a[17]), 32'h4);
    chk("wrap_i17_dat", iq_d[17], 32'h111);

    do_halt();
    load(0, 0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("empty_done_pulses", 32'(n_done), 32'd1);
    chk("empty_pc_stall", 32'(pc_stall), 32'd0);
    chk("empty_d_init_done", 32'(d_init_done), 32'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    do_halt();
    words[0] = 32'h5; words[1] = 32'h3; sum_skew = 32'h1;
    load(1, 1, 1'b0, 1'b0, 2);
    repeat (2) @(negedge clk);
    chk("csum_expected", expected_sum, 32'h9);
    chk("csum_sum_err", 32'(sum_err), 32'd1);
    chk("csum_pc_stall", 32'(pc_stall), 32'd1);
    chk("csum_no_done", 32'(n_done), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
